// File: rtl/byte_serializer_pkg.sv
// Shared definitions for the byte serializer: FSM encoding, word geometry
// and the in_len decode (code 2'b00 means a full four-byte word).
package byte_serializer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   localparam int unsigned WORD_BYTES    = 4;
   localparam logic [1:0]  LEN_CODE_FULL = 2'b00;
   localparam logic [1:0]  IDX_FIRST     = 2'd0;

   // Index of the final byte to emit for a given in_len code.
   function automatic logic [1:0] last_index(input logic [1:0] len);
      return (len == LEN_CODE_FULL) ? 2'(WORD_BYTES - 1) : len - 2'd1;
   endfunction

endpackage

// File: rtl/byte_sel.sv
// Combinational byte picker: maps an emission index onto a byte lane of a
// 32-bit word, either most-significant lane first or least-significant first.
module byte_sel
   import byte_serializer_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic [31:0] word_i,
   input  logic [1:0]  idx_i,
   output logic [7:0]  byte_o
);

   logic [1:0] lane;

   always_comb begin
      lane   = MSB_FIRST ? (2'(WORD_BYTES - 1) - idx_i) : idx_i;
      byte_o = word_i[{lane, 3'b000} +: 8];
   end

endmodule

// File: rtl/byte_serializer.sv
// Word-to-byte serializer with one active and one pending word slot, so a
// new word can be queued while the current one drains without a bubble.
module byte_serializer
   import byte_serializer_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic [1:0]  in_len,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        out_last
);

   state_e      state_q;
   logic [1:0]  idx_q;
   logic        pend_vld_q;
   logic [31:0] act_data_q, act_data_d;
   logic [1:0]  act_len_q, act_len_d;
   logic [31:0] pend_data_q, pend_data_d;
   logic [1:0]  pend_len_q, pend_len_d;

   logic        word_hs;
   logic        byte_hs;
   logic        last_byte;
   logic        load_act_in;
   logic        load_act_pend;
   logic        load_pend;
   logic [7:0]  sel_byte;

   // in_ready depends only on a flop, never on in_valid or out_ready.
   assign in_ready  = !pend_vld_q;
   assign out_valid = (state_q == ST_SEND);
   assign word_hs   = in_valid && in_ready;
   assign byte_hs   = out_valid && out_ready;
   assign last_byte = (idx_q == last_index(act_len_q));

   always_comb begin
      load_act_in   = 1'b0;
      load_act_pend = 1'b0;
      load_pend     = 1'b0;
      if (state_q == ST_IDLE) begin
         load_act_in = word_hs;
      end else if (byte_hs && last_byte) begin
         if (pend_vld_q) begin
            load_act_pend = 1'b1;
         end else begin
            load_act_in = word_hs;
         end
      end else begin
         load_pend = word_hs;
      end
   end

   always_comb begin
      act_data_d  = act_data_q;
      act_len_d   = act_len_q;
      pend_data_d = pend_data_q;
      pend_len_d  = pend_len_q;
      if (load_act_in) begin
         act_data_d = in_data;
         act_len_d  = in_len;
      end else if (load_act_pend) begin
         act_data_d = pend_data_q;
         act_len_d  = pend_len_q;
      end
      if (load_pend) begin
         pend_data_d = in_data;
         pend_len_d  = in_len;
      end
   end

   // Word payloads need no reset: they are only observed behind the valid flags.
   always_ff @(posedge clk) begin
      act_data_q  <= act_data_d;
      act_len_q   <= act_len_d;
      pend_data_q <= pend_data_d;
      pend_len_q  <= pend_len_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         idx_q      <= IDX_FIRST;
         pend_vld_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (load_act_in) begin
                  state_q <= ST_SEND;
                  idx_q   <= IDX_FIRST;
               end
            end
            ST_SEND: begin
               if (byte_hs) begin
                  if (last_byte) begin
                     idx_q <= IDX_FIRST;
                     if (!load_act_pend && !load_act_in) begin
                        state_q <= ST_IDLE;
                     end
                  end else begin
                     idx_q <= idx_q + 2'd1;
                  end
               end
               if (load_act_pend) begin
                  pend_vld_q <= 1'b0;
               end else if (load_pend) begin
                  pend_vld_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   byte_sel #(
      .MSB_FIRST(MSB_FIRST)
   ) u_byte_sel (
      .word_i(act_data_q),
      .idx_i (idx_q),
      .byte_o(sel_byte)
   );

   // Idle output is forced to zero rather than showing stale word data.
   assign out_data = out_valid ? sel_byte : 8'h00;
   assign out_last = out_valid && last_byte;

endmodule

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 Parameter MSB_FIRST, default 1: 1 = bits [31:24] emitted first (O1 order); 0 = bits [7:0] first.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 in_valid  input  1  upstream word valid.
REQ-005 in_ready  output  1  block can accept a word this cycle.
REQ-006 in_data  input  32  word to serialize.
REQ-007 in_len  input  2  bytes to emit from word: 1,2,3; 0 encodes 4.
REQ-008 out_valid  output  1  out_data holds a byte.
REQ-009 out_ready  input  1  downstream accepts byte.
REQ-010 out_data  output  8  current byte.
REQ-011 out_last  output  1  current byte is the final byte of its word.

Function
REQ-012 Word handshake occurs when in_valid && in_ready at a rising edge; byte handshake when out_valid && out_ready.
REQ-013 Storage: one active word register (data, len, byte index 0..3) plus one pending word register; each has a valid flag.
REQ-014 in_ready = !pending_valid; registered, no combinational path from in_valid or out_ready.
REQ-015 FSM states IDLE (active empty) and SEND (active valid); out_valid = 1 exactly in SEND.
REQ-016 IDLE + word handshake -> word loads into active register, index 0, SEND next cycle; first byte appears 1 cycle after handshake.
REQ-017 SEND + byte handshake, index < len-1 -> index increments, stay SEND.
REQ-018 SEND + byte handshake, index = len-1 (last) -> if pending valid: pending moves to active, index 0, pending cleared, stay SEND (no bubble); else if word handshake same cycle: incoming word loads into active, stay SEND; else -> IDLE.
REQ-019 SEND + word handshake without last-byte handshake -> word loads into pending register.
REQ-020 Byte selection: MSB_FIRST=1 emits in_data[31-8k -: 8] for index k; MSB_FIRST=0 emits in_data[8k +: 8].
REQ-021 in_len=1..3 emits only the first in_len bytes in the configured order; in_len=0 emits all 4.
REQ-022 out_last = out_valid && (index == len-1).
REQ-023 out_data, out_last stable while out_valid && !out_ready; out_data is 8'h00 when out_valid=0.
REQ-024 Sustained throughput 1 byte/cycle with out_ready held 1 and upstream supplying words.
REQ-025 No word is dropped or duplicated; bytes emitted in word-arrival order.

Reset
REQ-026 reset=0 forces, asynchronously: state IDLE, active/pending valid 0, index 0, out_valid 0, out_last 0, out_data 8'h00, in_ready 1.
REQ-027 Reset mid-word discards active and pending words; no byte of them is emitted after release.
REQ-028 Release synchronous to clk; first word handshake possible on first rising edge after release.

Structure
REQ-029 Shared package holds state encoding constants (IDLE, SEND) and the length-decode constant (2'b00 -> 4).
REQ-030 One sub-module, byte_sel: combinational 32-bit word + 2-bit index + MSB_FIRST -> 8-bit byte; the rest is flat in byte_serializer.

Verification
REQ-031 MSB_FIRST=1, word 32'hA1B2C3D4 len 0, out_ready=1 -> bytes A1,B2,C3,D4 on 4 consecutive cycles, out_last only on D4.
REQ-032 MSB_FIRST=0, word 32'h11223344 len 2 -> bytes 44,33, out_last on 33, then out_valid=0.
REQ-033 Back-to-back words 32'h01020304, 32'h05060708 (len 0) with out_ready=1 -> 8 bytes 01..08 on 8 consecutive cycles, no bubble; in_ready deasserts while pending full.
REQ-034 out_ready toggled 1,0,0,1,... on word 32'hDEADBEEF -> out_data holds during stalls; sequence DE,AD,BE,EF, each byte emitted exactly once.
REQ-035 reset=0 asserted after 2nd byte of 32'hCAFEF00D with pending word queued -> out_valid drops immediately, in_ready=1; after release no CA/FE/F0/0D or pending bytes emitted.
REQ-036 Random in_valid/out_ready, 1000 words of random len -> scoreboard matches byte stream and out_last positions exactly.
